// File: rtl/draw_pkg.sv
// Shared types and constants for the rectangle rasteriser.
package draw_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StDraw = 2'd1,
    StDone = 2'd2
  } draw_state_e;

  localparam int unsigned DEF_SCREEN_W = 160;
  localparam int unsigned DEF_SCREEN_H = 120;

  localparam logic MODE_FILL    = 1'b0;
  localparam logic MODE_OUTLINE = 1'b1;

endpackage

// File: rtl/rect_scan_counter.sv
// Row-major 2-D position counter: dx inner over 0..w-1, dy outer over 0..h-1.
module rect_scan_counter #(
  parameter int unsigned SIZE_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              step_i,
  input  logic [SIZE_W-1:0] w_i,
  input  logic [SIZE_W-1:0] h_i,
  output logic [SIZE_W-1:0] dx_o,
  output logic [SIZE_W-1:0] dy_o,
  output logic              last_o
);

  logic [SIZE_W-1:0] dx_q, dx_d;
  logic [SIZE_W-1:0] dy_q, dy_d;
  logic [SIZE_W-1:0] w_m1, h_m1;

  assign w_m1   = w_i - SIZE_W'(1);
  assign h_m1   = h_i - SIZE_W'(1);
  assign last_o = (dx_q == w_m1) && (dy_q == h_m1);
  assign dx_o   = dx_q;
  assign dy_o   = dy_q;

  // Holding at the last position keeps the counters from ever wrapping.
  always_comb begin
    dx_d = dx_q;
    dy_d = dy_q;
    if (clear_i) begin
      dx_d = '0;
      dy_d = '0;
    end else if (step_i && !last_o) begin
      if (dx_q == w_m1) begin
        dx_d = '0;
        dy_d = dy_q + SIZE_W'(1);
      end else begin
        dx_d = dx_q + SIZE_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dx_q <= '0;
      dy_q <= '0;
    end else begin
      dx_q <= dx_d;
      dy_q <= dy_d;
    end
  end

endmodule

// File: rtl/rect_draw_fsm.sv
// Rectangle rasteriser: one pixel per clock, filled or outline, clipped to the screen.
module rect_draw_fsm
  import draw_pkg::*;
#(
  parameter int unsigned X_W      = 8,
  parameter int unsigned Y_W      = 7,
  parameter int unsigned SIZE_W   = 5,
  parameter int unsigned COLOUR_W = 3,
  parameter int unsigned SCREEN_W = DEF_SCREEN_W,
  parameter int unsigned SCREEN_H = DEF_SCREEN_H
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                go,
  input  logic [X_W-1:0]      x_in,
  input  logic [Y_W-1:0]      y_in,
  input  logic [SIZE_W-1:0]   w_in,
  input  logic [SIZE_W-1:0]   h_in,
  input  logic                mode,
  input  logic [COLOUR_W-1:0] colour_in,
  output logic [X_W-1:0]      out_x,
  output logic [Y_W-1:0]      out_y,
  output logic [COLOUR_W-1:0] out_colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);

  draw_state_e state_q, state_d;

  logic [X_W-1:0]      x0_q, x0_d;
  logic [Y_W-1:0]      y0_q, y0_d;
  logic [SIZE_W-1:0]   w_q, w_d;
  logic [SIZE_W-1:0]   h_q, h_d;
  logic                mode_q, mode_d;
  logic [COLOUR_W-1:0] colour_q, colour_d;

  logic              start;
  logic [SIZE_W-1:0] dx, dy;
  logic              last;
  logic [X_W:0]      sum_x;
  logic [Y_W:0]      sum_y;
  logic              visible, on_edge;

  assign start = (state_q == StIdle) && go;

  rect_scan_counter #(
    .SIZE_W (SIZE_W)
  ) u_scan (
    .clk     (clk),
    .reset   (reset),
    .clear_i (start),
    .step_i  (state_q == StDraw),
    .w_i     (w_q),
    .h_i     (h_q),
    .dx_o    (dx),
    .dy_o    (dy),
    .last_o  (last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      x0_q     <= '0;
      y0_q     <= '0;
      w_q      <= '0;
      h_q      <= '0;
      mode_q   <= MODE_FILL;
      colour_q <= '0;
    end else begin
      state_q  <= state_d;
      x0_q     <= x0_d;
      y0_q     <= y0_d;
      w_q      <= w_d;
      h_q      <= h_d;
      mode_q   <= mode_d;
      colour_q <= colour_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    x0_d     = x0_q;
    y0_d     = y0_q;
    w_d      = w_q;
    h_d      = h_q;
    mode_d   = mode_q;
    colour_d = colour_q;
    unique case (state_q)
      StIdle: begin
        if (go) begin
          x0_d     = x_in;
          y0_d     = y_in;
          w_d      = w_in;
          h_d      = h_in;
          mode_d   = mode;
          colour_d = colour_in;
          state_d  = ((w_in != '0) && (h_in != '0)) ? StDraw : StDone;
        end
      end
      StDraw:  if (last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Sums carry one extra bit so positions past the coordinate range still clip.
  assign sum_x = {1'b0, x0_q} + (X_W + 1)'(dx);
  assign sum_y = {1'b0, y0_q} + (Y_W + 1)'(dy);

  always_comb begin
    visible    = (sum_x < (X_W + 1)'(SCREEN_W)) && (sum_y < (Y_W + 1)'(SCREEN_H));
    on_edge    = (dx == '0) || (dx == w_q - SIZE_W'(1)) ||
                 (dy == '0) || (dy == h_q - SIZE_W'(1));
    out_x      = sum_x[X_W-1:0];
    out_y      = sum_y[Y_W-1:0];
    out_colour = colour_q;
    busy       = (state_q == StDraw);
    done       = (state_q == StDone);
    plot       = busy && visible && ((mode_q == MODE_FILL) || on_edge);
  end

endmodule
